// File: rtl/uart_tx_buffer_if.sv
// Character/serial bundle between the core-side producer and the UART transmit buffer.
interface uart_tx_buffer_if #(
   parameter int ADDR_W = 3
);
   logic [8:0]      uart_in;     // [8] write strobe, [7:0] character
   logic            tx;          // serial line, idle high
   logic            tx_busy;     // frame in flight or characters queued
   logic            tx_done;     // one-cycle pulse at end of stop bit
   logic [ADDR_W:0] fifo_level;  // characters currently queued
   logic            overflow;    // sticky dropped-character flag

   // Producer side: drives characters, observes the line and status.
   modport master (
      output uart_in,
      input  tx, tx_busy, tx_done, fifo_level, overflow
   );

   // Buffer side: consumes characters, drives the line and status.
   modport slave (
      input  uart_in,
      output tx, tx_busy, tx_done, fifo_level, overflow
   );
endinterface

// File: rtl/uart_tx_buffer.sv
// Small character FIFO feeding an 8N1 serialiser (1 start, 8 data LSB-first, 1 stop).
// The head character is popped only from IDLE, so consecutive frames are separated
// by exactly one idle-high cycle. The line output is registered.
module uart_tx_buffer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_W       = 3
) (
   input  logic              clock,
   input  logic              reset,
   uart_tx_buffer_if.slave   uart_if
);
   localparam int                TMR_W      = $clog2(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   level_q;
   logic              overflow_q;

   logic              strobe;
   logic              full;
   logic              bit_end;
   logic              pop;
   logic              push;

   assign strobe  = uart_if.uart_in[8];
   assign full    = (level_q == LEVEL_FULL);
   assign bit_end = (timer_q == TMR_LAST);
   // A pop frees a slot on the same edge, so a full FIFO can still accept then.
   assign pop     = (state_q == S_IDLE) && (level_q != '0);
   assign push    = strobe && (!full || pop);

   // State register, FIFO bookkeeping and registered line outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
            default: level_q <= level_q;
         endcase
         if (strobe && !push) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Character storage; no reset so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= uart_if.uart_in[7:0];
      end
   end

   // Next-state logic: bit timer, bit index and shift register sequencing.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_START;
               timer_d = '0;
               shift_d = mem_q[rd_ptr_q];
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               timer_d = '0;
               idx_d   = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               shift_d = shift_q >> 1;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: line level for the upcoming state, done on the last stop-bit cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_q == S_STOP) && bit_end;
   end

   assign uart_if.tx         = tx_q;
   assign uart_if.tx_busy    = (state_q != S_IDLE) || (level_q != '0);
   assign uart_if.tx_done    = done_q;
   assign uart_if.fifo_level = level_q;
   assign uart_if.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a frame-timeline reference model checked
// every cycle, a table of single-character vectors, hand sequences and random traffic.
module tb_uart_tx_buffer;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   uart_tx_buffer_if #(.ADDR_W(AW)) uif ();

   uart_tx_buffer #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .ADDR_W       (AW)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .uart_if (uif)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: queue of accepted characters plus the pop edge of the
   // current frame; the line level is derived from elapsed cycles since that edge.
   byte unsigned mq[$];
   bit           m_have = 1'b0;
   longint       m_fp   = 0;
   byte unsigned m_fc   = 8'h00;
   bit           m_ovf  = 1'b0;
   longint       mn     = 0;
   bit           m_tx   = 1'b1;
   bit           m_busy = 1'b0;
   bit           m_done = 1'b0;
   int           m_level = 0;
   bit           model_on = 1'b0;

   int peak_level = 0;
   int done_cnt   = 0;
   int tx_low_cnt = 0;

   typedef struct {
      int         off;    // cycles after the first edge of the sequence
      logic [8:0] din;    // uart_in applied on the edge reaching this offset
      logic       tx;
      int         level;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  sz;
      int  k;
      bit  idle;
      bit  pop;
      bit  in_frame;
      mn++;
      if (reset) begin
         mq.delete();
         m_have = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         sz   = mq.size();
         idle = !m_have || (mn >= m_fp + 41);
         pop  = idle && (sz > 0);
         if (pop) begin
            m_fc   = mq.pop_front();
            m_fp   = mn;
            m_have = 1'b1;
         end
         if (uif.uart_in[8]) begin
            if (sz < DEPTH || pop) mq.push_back(uif.uart_in[7:0]);
            else m_ovf = 1'b1;
         end
      end
      in_frame = m_have && (mn < m_fp + 10 * CPB);
      m_done   = m_have && (mn == m_fp + 10 * CPB);
      m_tx     = 1'b1;
      if (in_frame) begin
         k = int'((mn - m_fp) / CPB);
         if (k == 0) m_tx = 1'b0;
         else if (k == 9) m_tx = 1'b1;
         else m_tx = m_fc[k-1];
      end
      m_level = mq.size();
      m_busy  = in_frame || (m_level != 0);
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      if (model_on) begin
         chk("model_tx",    32'(uif.tx),         32'(m_tx));
         chk("model_busy",  32'(uif.tx_busy),    32'(m_busy));
         chk("model_done",  32'(uif.tx_done),    32'(m_done));
         chk("model_level", 32'(uif.fifo_level), 32'(m_level));
         chk("model_ovf",   32'(uif.overflow),   32'(m_ovf));
         if (int'(uif.fifo_level) > peak_level) peak_level = int'(uif.fifo_level);
         if (uif.tx_done === 1'b1) done_cnt++;
         if (uif.tx !== 1'b1) tx_low_cnt++;
      end
   endtask

   task automatic send(input logic [7:0] ch);
      uif.uart_in = {1'b1, ch};
      step();
      uif.uart_in = 9'h000;
   endtask

   initial begin
      longint e0;
      int     off;

      // Single character 0x41: bits 0,1,0,0,0,0,0,1,0,1 at 4 cycles each from E1.
      tbl[0]  = '{0,  9'h141, 1'b1, 1, 1'b1, 1'b0};
      tbl[1]  = '{1,  9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[2]  = '{4,  9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[3]  = '{5,  9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[4]  = '{8,  9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[5]  = '{9,  9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[6]  = '{28, 9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[7]  = '{29, 9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[8]  = '{32, 9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[9]  = '{33, 9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[10] = '{36, 9'h000, 1'b0, 0, 1'b1, 1'b0};
      tbl[11] = '{37, 9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[12] = '{40, 9'h000, 1'b1, 0, 1'b1, 1'b0};
      tbl[13] = '{41, 9'h000, 1'b1, 0, 1'b0, 1'b1};
      tbl[14] = '{42, 9'h000, 1'b1, 0, 1'b0, 1'b0};

      uif.uart_in = 9'h000;
      reset = 1'b1;
      step();
      model_on = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_tx",    32'(uif.tx),         32'd1);
      chk("reset_busy",  32'(uif.tx_busy),    32'd0);
      chk("reset_done",  32'(uif.tx_done),    32'd0);
      chk("reset_level", 32'(uif.fifo_level), 32'd0);
      chk("reset_ovf",   32'(uif.overflow),   32'd0);

      // Idle line
      tx_low_cnt = 0;
      done_cnt   = 0;
      repeat (100) step();
      chk("idle_tx_low_cycles", 32'(tx_low_cnt), 32'd0);
      chk("idle_done_pulses",   32'(done_cnt),   32'd0);
      chk("idle_busy",          32'(uif.tx_busy), 32'd0);
      $display("idle: 100 cycles, tx_low=%0d done=%0d", tx_low_cnt, done_cnt);

      // Table-driven single character
      off = -1;
      for (int i = 0; i < 15; i++) begin
         while (off < tbl[i].off - 1) begin
            uif.uart_in = 9'h000;
            step();
            off++;
         end
         uif.uart_in = tbl[i].din;
         step();
         off++;
         uif.uart_in = 9'h000;
         chk($sformatf("vec%0d_tx", i),    32'(uif.tx),         32'(tbl[i].tx));
         chk($sformatf("vec%0d_level", i), 32'(uif.fifo_level), 32'(tbl[i].level));
         chk($sformatf("vec%0d_busy", i),  32'(uif.tx_busy),    32'(tbl[i].busy));
         chk($sformatf("vec%0d_done", i),  32'(uif.tx_done),    32'(tbl[i].done));
         $display("vec%0d off=%0d tx=%0b level=%0d busy=%0b done=%0b", i, off,
                  uif.tx, uif.fifo_level, uif.tx_busy, uif.tx_done);
      end
      repeat (5) step();

      // Burst of three
      peak_level = 0;
      done_cnt   = 0;
      send(8'h48);
      send(8'h69);
      send(8'h0A);
      repeat (140) step();
      chk("burst_peak_level", 32'(peak_level), 32'd2);
      chk("burst_done_count", 32'(done_cnt),   32'd3);
      chk("burst_overflow",   32'(uif.overflow), 32'd0);
      $display("burst: peak=%0d done=%0d ovf=%0b", peak_level, done_cnt, uif.overflow);

      // Overflow: ten strobes into an eight-deep FIFO
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         send(8'(8'h30 + i));
         chk($sformatf("ovf_after_E%0d", i), 32'(uif.overflow), (i == 9) ? 32'd1 : 32'd0);
      end
      repeat (400) step();
      chk("ovf_sticky",     32'(uif.overflow), 32'd1);
      chk("ovf_done_count", 32'(done_cnt),     32'd9);
      $display("overflow: ovf=%0b frames=%0d", uif.overflow, done_cnt);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("ovf_cleared_by_reset", 32'(uif.overflow), 32'd0);

      // Simultaneous push and pop while full
      done_cnt = 0;
      send(8'hA0);
      e0 = mn;
      for (int i = 1; i <= 8; i++) send(8'(8'hA0 + i));
      chk("full_level", 32'(uif.fifo_level), 32'd8);
      while (mn < e0 + 41) step();
      send(8'h55);
      chk("pushpop_level", 32'(uif.fifo_level), 32'd8);
      chk("pushpop_ovf",   32'(uif.overflow),   32'd0);
      repeat (9 * 41 + 10) step();
      chk("pushpop_done_count", 32'(done_cnt),         32'd10);
      chk("pushpop_drained",    32'(uif.fifo_level),   32'd0);
      $display("pushpop: frames=%0d level=%0d", done_cnt, uif.fifo_level);

      // Reset mid-frame during data bit 3 with two characters queued
      send(8'h11);
      e0 = mn;
      send(8'h22);
      send(8'h33);
      while (mn < e0 + 17) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_tx",    32'(uif.tx),         32'd1);
      chk("midrst_level", 32'(uif.fifo_level), 32'd0);
      chk("midrst_busy",  32'(uif.tx_busy),    32'd0);
      chk("midrst_ovf",   32'(uif.overflow),   32'd0);
      chk("midrst_done",  32'(uif.tx_done),    32'd0);
      done_cnt = 0;
      repeat (60) step();
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      send(8'h5A);
      repeat (50) step();
      chk("midrst_recover_done", 32'(done_cnt), 32'd1);
      $display("midreset: recovered frames=%0d", done_cnt);

      // Random traffic against the model, with varying strobe density and rare resets
      for (int i = 0; i < 3000; i++) begin
         int rate;
         rate = (i < 1000) ? 60 : (i < 2000) ? 15 : 3;
         reset = ($urandom_range(0, 999) == 0);
         uif.uart_in = {($urandom_range(0, rate - 1) == 0), 8'($urandom)};
         step();
         reset = 1'b0;
         uif.uart_in = 9'h000;
      end
      repeat (500) step();
      $display("random: 3000 cycles done, level=%0d", uif.fifo_level);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Downstream consumer of the RV32IM core's 9-bit UART output port: bit 8 is a one-cycle write strobe and bits 7:0 are the character.
- Buffers characters in a small FIFO and serialises them onto a single 8N1 line (1 start, 8 data LSB-first, 1 stop).
- Sits between the core and the board/simulation UART pin; lets the bench or FPGA top observe real serial traffic instead of raw strobes.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (>=2); small default keeps simulation short.
FIFO_DEPTH, 8, number of character slots; must be a power of two.
ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
uart_in  input  9  [8] write strobe, [7:0] character, driven by the core.
tx  output  1  serial line, idle high.
tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty.
tx_done  output  1  one-cycle pulse at the end of each frame's stop bit.
fifo_level  output  ADDR_W+1  characters currently queued, 0..FIFO_DEPTH.
overflow  output  1  sticky; set when a strobe arrives with no room.

Behaviour:
- Reset, sampled on a clock edge with reset=1:
  - tx=1, tx_busy=0, tx_done=0, fifo_level=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers go to 0.
  - Reset mid-frame aborts the frame; tx is high from the next cycle and the queued data is discarded.
- Push: on an edge with uart_in[8]=1, uart_in[7:0] is written at the write pointer when fifo_level<FIFO_DEPTH, or when a pop occurs on the same edge.
  - Otherwise the character is dropped and overflow is set. overflow stays set until reset.
  - A push/pop on the same edge when full leaves fifo_level unchanged and accepts the character.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is updated +1 on push only, -1 on pop only, and unchanged on both or neither.
- FSM states: IDLE, START, DATA, STOP. One bit-timer counts 0..CLKS_PER_BIT-1, and a bit index counts 0..7.
  - IDLE: tx=1. If fifo_level!=0 on an edge, pop the head into the shift register, clear the timer, and go to START. Pop occurs only here.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done=1 for exactly that one cycle.
- Latency:
  - A strobe sampled at edge E0 into an empty, idle block makes tx low from edge E1.
  - The frame occupies 10*CLKS_PER_BIT cycles.
  - tx_done is high for the cycle following edge E1+10*CLKS_PER_BIT.
- Back-to-back frames have exactly one idle-high cycle (the IDLE pop cycle) between a stop bit and the next start bit.
- tx is registered (no combinational path from uart_in to tx).
- tx_busy = (state!=IDLE) | (fifo_level!=0), registered-equivalent.
- Strobes during a frame are queued and never disturb the frame in flight.

Test Plan:
- Single char, CLKS_PER_BIT=4:
  - Stimulus: uart_in=9'h141 at E0.
  - Required: tx bits 0,1,0,0,0,0,0,1,0,1, each 4 cycles, starting E1; tx_done pulse after E41; fifo_level 1 after E0 and 0 after E1; tx_busy drops with tx_done.
- Burst of three:
  - Stimulus: strobes 0x48,0x69,0x0A on consecutive edges.
  - Required: fifo_level peaks at 2; three frames in order; exactly 1 idle cycle between frames; three tx_done pulses; overflow=0.
- Overflow:
  - Stimulus: 10 strobes (0x30..0x39) on consecutive edges, DEPTH=8.
  - Required: 0x30 popped at E1; 0x39 dropped; overflow=1 from the edge after E9 until reset; 0x30..0x38 transmitted in order.
- Simultaneous push/pop at full:
  - Stimulus: fill to 8 during a frame, then strobe 0x55 on the IDLE pop edge.
  - Required: fifo_level stays 8; overflow stays 0; 0x55 transmitted last.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 with 2 chars queued.
  - Required: next cycle tx=1, fifo_level=0, tx_busy=0, overflow=0; no tx_done; a new strobe after reset transmits normally.
- Idle line:
  - Stimulus: no strobes for 100 cycles after reset.
  - Required: tx constantly 1; tx_busy=0; tx_done never asserted.
